// File: rtl/ram_pattern_checker_if.sv
// rtl/ram_pattern_checker_if.sv - single-port RAM read/write port bundle
// The checker is the master; the RAM (or a RAM model) is the slave.
interface ram_pattern_checker_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic [AW-1:0] addr;
    logic          wren;
    logic [DW-1:0] q;

    modport master (
        output addr,
        output wren,
        input  q
    );

    modport slave (
        input  addr,
        input  wren,
        output q
    );
endinterface

// File: rtl/ram_pattern_checker.sv
// rtl/ram_pattern_checker.sv - sweeps a single-port RAM and checks it against a (a + SEED) pattern
// Reports pass/fail, a saturating error count and the first failing word.
module ram_pattern_checker #(
    parameter int          AW     = 8,
    parameter int          DW     = 8,
    parameter int          RD_LAT = 2,
    parameter int unsigned SEED   = 8'h03
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    ram_pattern_checker_if.master  ram,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [15:0]            err_cnt,
    output logic [AW-1:0]          first_err_addr,
    output logic [DW-1:0]          first_err_data,
    output logic [7:0]             led
);
    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    localparam logic [AW-1:0] LAST_ADDR = '1;
    localparam int            LAST_STG  = RD_LAT - 1;

    state_t        state;
    logic [AW-1:0] ram_addr;
    logic [2:0]    drain_cnt;

    // Each stage tags the address whose data will be on ram_q when it reaches the last stage.
    logic [RD_LAT-1:0] pv;
    logic [AW-1:0]     pa [RD_LAT];

    logic          mismatch;
    logic [15:0]   err_next;

    function automatic logic [DW-1:0] expected(input logic [AW-1:0] a);
        return DW'(32'(a) + SEED);
    endfunction

    assign mismatch = pv[LAST_STG] && (ram.q != expected(pa[LAST_STG]));
    assign err_next = (mismatch && err_cnt != 16'hFFFF) ? err_cnt + 16'd1 : err_cnt;

    assign ram.addr = ram_addr;
    assign ram.wren = 1'b0;
    assign led      = {err_cnt[4:0], busy, pass & done, done};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            ram_addr       <= '0;
            drain_cnt      <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
            pv             <= '0;
            for (int i = 0; i < RD_LAT; i++) pa[i] <= '0;
        end else begin
            pv[0] <= (state == S_READ);
            pa[0] <= ram_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                pv[i] <= pv[i-1];
                pa[i] <= pa[i-1];
            end

            if (mismatch) begin
                err_cnt <= err_next;
                if (err_cnt == 16'd0) begin
                    first_err_addr <= pa[LAST_STG];
                    first_err_data <= ram.q;
                end
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state          <= S_READ;
                        ram_addr       <= '0;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        err_cnt        <= '0;
                        first_err_addr <= '0;
                        first_err_data <= '0;
                    end
                end
                S_READ: begin
                    if (ram_addr == LAST_ADDR) begin
                        state     <= S_DRAIN;
                        drain_cnt <= '0;
                    end else begin
                        ram_addr <= ram_addr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    // The final compare lands on this same edge, so pass uses err_next.
                    if (drain_cnt == 3'(RD_LAT - 1)) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == 16'd0);
                    end else begin
                        drain_cnt <= drain_cnt + 3'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
